// File: rtl/clock_pkg.sv
// Shared BCD limits and timer state encodings
// for the clock counter chain and countdown timer.
package clock_pkg;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ALARM = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  function automatic logic [3:0] clamp(
    input logic [3:0] d,
    input logic [3:0] max
  );
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with load and
// combinational borrow into the next digit.
module bcd_down_digit
  import clock_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       dec,
  input  logic       ld,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic       borrow
);

  assign borrow = (q == 4'd0) && dec;

  always_ff @(posedge CP) begin
    if (reset) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= d;
    end else if (dec) begin
      q <= (q == 4'd0) ? MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with done pulse and
// an alarm held for ALARM_TICKS strobes.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int ALARM_TICKS = 10
) (
  input  logic       CP,
  input  logic       reset,
  input  logic       EN,
  input  logic       load,
  input  logic [7:0] preset_m,
  input  logic [7:0] preset_s,
  input  logic       run,
  input  logic       decre,
  output logic [7:0] Q_m,
  output logic [7:0] Q_s,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [7:0] TICKS = 8'(ALARM_TICKS);

  state_t      state_q, state_d;
  logic [7:0]  tick_q, tick_d;
  logic        done_d;
  logic [15:0] pre;
  logic        is_idle, is_run;
  logic        zero, last;
  logic        dec_req, step, hit_zero;
  logic        b_su, b_st, b_mu, b_mt;

  assign pre = {clamp(preset_m[7:4], DIGIT_MAX),
                clamp(preset_m[3:0], DIGIT_MAX),
                clamp(preset_s[7:4], SEC_TENS_MAX),
                clamp(preset_s[3:0], DIGIT_MAX)};

  assign is_idle = (state_q == ST_IDLE);
  assign is_run  = (state_q == ST_RUN);
  assign zero    = ({Q_m, Q_s} == 16'h0000);
  assign last    = ({Q_m, Q_s} == 16'h0001);

  // decre and EN together still give a single step
  assign dec_req = !load &&
                   ((decre && (is_idle || is_run)) ||
                    (EN && is_run && run));
  assign step     = dec_req && !zero;
  assign hit_zero = step && last;

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_su (
    .CP(CP), .reset(reset), .dec(step), .ld(load),
    .d(pre[3:0]), .q(Q_s[3:0]), .borrow(b_su)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX)) u_st (
    .CP(CP), .reset(reset), .dec(b_su), .ld(load),
    .d(pre[7:4]), .q(Q_s[7:4]), .borrow(b_st)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mu (
    .CP(CP), .reset(reset), .dec(b_st), .ld(load),
    .d(pre[11:8]), .q(Q_m[3:0]), .borrow(b_mu)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX)) u_mt (
    .CP(CP), .reset(reset), .dec(b_mu), .ld(load),
    .d(pre[15:12]), .q(Q_m[7:4]), .borrow(b_mt)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    done_d  = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run && !zero && !hit_zero)
            state_d = ST_RUN;
        end
        ST_RUN: begin
          if (hit_zero) begin
            state_d = ST_ALARM;
            tick_d  = 8'd0;
            done_d  = 1'b1;
          end else if (!run || zero || b_mt) begin
            state_d = ST_IDLE;
          end
        end
        ST_ALARM: begin
          if (EN) begin
            tick_d = tick_q + 8'd1;
            if (tick_d == TICKS)
              state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CP) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= 8'd0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      done    <= done_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign alarm   = (state_q == ST_ALARM);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with
// ALARM_TICKS = 3.
module tb_countdown_timer;

  logic       CP = 1'b0;
  logic       reset = 1'b1;
  logic       EN = 1'b0;
  logic       load = 1'b0;
  logic [7:0] preset_m = 8'h00;
  logic [7:0] preset_s = 8'h00;
  logic       run = 1'b0;
  logic       decre = 1'b0;
  logic [7:0] Q_m, Q_s;
  logic       running, done, alarm;

  int n_tests = 0;
  int n_fail  = 0;

  countdown_timer #(.ALARM_TICKS(3)) dut (
    .CP(CP), .reset(reset), .EN(EN), .load(load),
    .preset_m(preset_m), .preset_s(preset_s),
    .run(run), .decre(decre),
    .Q_m(Q_m), .Q_s(Q_s),
    .running(running), .done(done), .alarm(alarm)
  );

  always #5 CP = ~CP;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CP);
    #1;
  endtask

  task automatic do_load(
    input logic [7:0] m,
    input logic [7:0] s
  );
    preset_m = m;
    preset_s = s;
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic tick();
    EN = 1'b1;
    cyc();
    EN = 1'b0;
  endtask

  initial begin
    cyc();
    cyc();
    reset = 1'b0;
    check("rst_q", {Q_m, Q_s}, 16'h0000);
    check("rst_flags", {13'b0, running, done, alarm}, 16'h0);

    do_load(8'h01, 8'h05);
    check("load_0105", {Q_m, Q_s}, 16'h0105);
    run = 1'b1;
    cyc();
    check("run_on", {15'b0, running}, 16'h1);
    for (int i = 0; i < 5; i++) tick();
    check("cnt_0100", {Q_m, Q_s}, 16'h0100);
    tick();
    check("borrow_0059", {Q_m, Q_s}, 16'h0059);

    do_load(8'h00, 8'h02);
    check("load_idle", {15'b0, running}, 16'h0);
    cyc();
    tick();
    check("cnt_0001", {Q_m, Q_s}, 16'h0001);
    check("no_done_yet", {15'b0, done}, 16'h0);
    tick();
    check("cnt_0000", {Q_m, Q_s}, 16'h0000);
    check("done_alarm", {13'b0, running, done, alarm}, 16'h3);
    cyc();
    check("done_pulse", {15'b0, done}, 16'h0);
    tick();
    tick();
    check("alarm_hold", {15'b0, alarm}, 16'h1);
    tick();
    check("alarm_end", {14'b0, running, alarm}, 16'h0);
    cyc();
    check("zero_no_run", {15'b0, running}, 16'h0);

    do_load(8'h10, 8'h00);
    cyc();
    tick();
    check("borrow_0959", {Q_m, Q_s}, 16'h0959);
    run = 1'b0;
    cyc();
    check("pause_flag", {15'b0, running}, 16'h0);
    for (int i = 0; i < 5; i++) tick();
    check("pause_hold", {Q_m, Q_s}, 16'h0959);

    run = 1'b1;
    do_load(8'h00, 8'h10);
    cyc();
    EN = 1'b1;
    decre = 1'b1;
    cyc();
    EN = 1'b0;
    decre = 1'b0;
    check("single_step", {Q_m, Q_s}, 16'h0009);
    run = 1'b0;
    cyc();
    do_load(8'h00, 8'h01);
    decre = 1'b1;
    cyc();
    decre = 1'b0;
    check("idle_dec", {Q_m, Q_s}, 16'h0000);
    check("idle_no_done", {14'b0, done, alarm}, 16'h0);
    decre = 1'b1;
    cyc();
    decre = 1'b0;
    check("floor", {Q_m, Q_s}, 16'h0000);

    do_load(8'hAF, 8'h7C);
    check("clamp", {Q_m, Q_s}, 16'h9959);

    do_load(8'h00, 8'h01);
    run = 1'b1;
    cyc();
    tick();
    check("alarm_on", {15'b0, alarm}, 16'h1);
    run = 1'b0;
    do_load(8'h12, 8'h34);
    check("abort_q", {Q_m, Q_s}, 16'h1234);
    check("abort_flags", {14'b0, running, alarm}, 16'h0);

    do_load(8'h05, 8'h30);
    run = 1'b1;
    cyc();
    check("pre_rst_run", {15'b0, running}, 16'h1);
    reset = 1'b1;
    EN = 1'b1;
    cyc();
    check("rst_mid_q", {Q_m, Q_s}, 16'h0000);
    check("rst_mid_fl", {13'b0, running, done, alarm}, 16'h0);
    #4;
    check("rst_between", {Q_m, Q_s, 13'b0}, 16'h0000);
    reset = 1'b0;
    EN = 1'b0;
    run = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Four-digit BCD MM:SS countdown timer: the down-counting counterpart of the clock's mod-10/mod-6 up-counters. It is loaded with a preset and decremented once per 1 Hz `EN` strobe while running. On reaching 00:00 it pulses `done` and holds `alarm` for a programmable number of ticks. It sits beside the time-of-day counter chain, fed by the same 1 Hz strobe and debounced buttons, and drives the same digit display mux.

## Interface
- `ALARM_TICKS`, default 10: number of `EN` strobes `alarm` stays high (1..255)
- `CP`  in  1  system clock, all logic on posedge
- `reset`  in  1  synchronous, active-high; sampled on posedge `CP`
- `EN`  in  1  1 Hz tick strobe, high for exactly one `CP` cycle
- `load`  in  1  one-cycle pulse: copy preset into count
- `preset_m`  in  8  BCD minutes {tens, units}, 00..99
- `preset_s`  in  8  BCD seconds {tens, units}, 00..59
- `run`  in  1  level: 1 = count down, 0 = pause
- `decre`  in  1  one-cycle debounced button pulse: manual −1 s
- `Q_m`  out  8  current BCD minutes
- `Q_s`  out  8  current BCD seconds
- `running`  out  1  high in RUN state
- `done`  out  1  one-cycle pulse on reaching 00:00 in RUN
- `alarm`  out  1  high in ALARM state

## Operation
- States: IDLE (00), RUN (01), ALARM (10). Code 11 is illegal and returns to IDLE next cycle.
- Reset: state IDLE; `Q_m`=`Q_s`=8'h00; `running`=`done`=`alarm`=0; alarm tick count 0.
- Per-cycle priority: `reset` > `load` > `decre` > (`EN` & RUN).
- `load`:
  - Count ← preset; state ← IDLE from any state.
  - Preset clamping per digit: units >9 → 9; seconds tens >5 → 5; minutes tens >9 → 9.
- IDLE → RUN when `run`=1 and count ≠ 00:00. With count = 00:00 and `run`=1, stay IDLE.
- RUN:
  - `run`=0 → IDLE; count is held (pause).
  - On `EN`, count −1 s.
  - If the result is 00:00: `done`=1 for that cycle, state → ALARM, tick count cleared.
- Decrement is a borrow chain:
  - s-units 0→9 borrows from s-tens.
  - s-tens 0→5 borrows from m-units.
  - m-units 0→9 borrows from m-tens.
  - Example: 10:00 → 09:59.
  - Floor: count 00:00 never wraps; decrement is a no-op.
- `decre`:
  - Decrements in IDLE or RUN.
  - When it coincides with `EN` in RUN, exactly one decrement occurs.
  - Reaching 00:00 via `decre` in RUN behaves like `EN` (done, ALARM).
  - Reaching 00:00 via `decre` in IDLE gives no `done` or `alarm`.
  - Ignored in ALARM.
- ALARM:
  - `alarm`=1; count stays 00:00.
  - Each `EN` increments the tick count; on the `ALARM_TICKS`-th `EN`, state → IDLE.
  - `load` aborts to IDLE; `run` is ignored.

## Timing
- All outputs are registered. Any change sampled at posedge k is visible after posedge k, i.e. one-cycle latency from `EN`/`load`/`decre`.
- `done` is high in the same cycle `Q` first reads 00:00; `alarm` and `running`=0 follow the state in the same cycle.
- `running` deasserts the cycle after `run` falls is sampled.
- Reset mid-countdown or mid-alarm clears everything on the next posedge, with no residual `done`.
- `load` in the same cycle as `EN` in RUN: load wins, no decrement, state IDLE.
- `EN` stuck high counts once per `CP` cycle. Strobe width is the caller's responsibility.

## Structure
- Shared package `clock_pkg`:
  - BCD limits: `SEC_TENS_MAX`=4'd5, `DIGIT_MAX`=4'd9.
  - State encodings `ST_IDLE`, `ST_RUN`, `ST_ALARM`.
  - Shared with the up-counter chain.
- Sub-module `bcd_down_digit`:
  - Ports: `MAX` parameter, `dec`, `ld`, `d`, `q`, `borrow`.
  - `borrow` is combinational (q==0 & dec); it is instantiated 4×.
  - Parent gates the chain with the 00:00 floor.
- The top level holds the FSM, clamping, and the 8-bit alarm tick counter.

## Test plan
- Reset, then `load` 01:05, `run`=1, 5 `EN` → `Q`=01:00; 1 more `EN` → 00:59.
- `load` 00:02, run, 2 `EN` → `Q`=00:00 with `done` pulse on that cycle, `alarm`=1. With `ALARM_TICKS`=3, after 3 `EN` → `alarm`=0, state IDLE.
- Pause: run 10:00, 1 `EN` → 09:59; `run`=0, 5 `EN` → still 09:59, `running`=0.
- `decre`+`EN` same cycle in RUN at 00:10 → 00:09 (single step). `decre` in IDLE at 00:01 → 00:00, no `done`, no `alarm`; further `decre` → 00:00.
- `load` 8'hAF/8'h7C → clamped to 99:59. `load` asserted during ALARM → IDLE, count = preset.
- Synchronous reset asserted mid-RUN at 05:30 → next cycle 00:00, IDLE, all flags 0. No change between edges while reset is high.
